// File: rtl/wfr_sample_decimator.sv
// Decimates a multi-channel sample stream by 2^k in pick or boxcar-average mode, folding window triggers onto the output.
// Optional build macro WFR_DECIM_ROUND_EN: average mode rounds half-up instead of flooring.
module wfr_sample_decimator #(
    parameter int CHANNELS        = 4,
    parameter int SAMPLE_WIDTH    = 32,
    parameter int MAX_LOG2_DECIM  = 8,
    parameter int TIMESTAMP_WIDTH = 64,
    parameter int TRIGGER_WIDTH   = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [3:0]                         cfgLog2Decim,
    input  logic                               cfgAverage,
    input  logic                               cfgUpdate,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0]   inData,
    input  logic                               inValid,
    input  logic [TRIGGER_WIDTH-1:0]           inTriggers,
    input  logic [TIMESTAMP_WIDTH-1:0]         inTimestamp,
    output logic [CHANNELS*SAMPLE_WIDTH-1:0]   outData,
    output logic                               outValid,
    output logic [TRIGGER_WIDTH-1:0]           outTriggers,
    output logic [TIMESTAMP_WIDTH-1:0]         outTimestamp,
    output logic [MAX_LOG2_DECIM-1:0]          windowPhase
);

    localparam int DATA_WIDTH = CHANNELS * SAMPLE_WIDTH;
    localparam int ACC_WIDTH  = SAMPLE_WIDTH + MAX_LOG2_DECIM;
    localparam int K_WIDTH    = $clog2(MAX_LOG2_DECIM + 1);

    localparam logic [K_WIDTH-1:0]         K_MAX      = K_WIDTH'(MAX_LOG2_DECIM);
    localparam logic [MAX_LOG2_DECIM-1:0]  PHASE_ZERO = {MAX_LOG2_DECIM{1'b0}};
    localparam logic [MAX_LOG2_DECIM-1:0]  PHASE_ONE  = {{(MAX_LOG2_DECIM-1){1'b0}}, 1'b1};
    localparam logic [MAX_LOG2_DECIM-1:0]  PHASE_ALL  = {MAX_LOG2_DECIM{1'b1}};
    localparam logic [ACC_WIDTH-1:0]       ACC_ZERO   = {ACC_WIDTH{1'b0}};
    localparam logic [ACC_WIDTH-1:0]       ACC_ONE    = {{(ACC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TRIGGER_WIDTH-1:0]   TRIG_ZERO  = {TRIGGER_WIDTH{1'b0}};
    localparam logic [TIMESTAMP_WIDTH-1:0] TS_ZERO    = {TIMESTAMP_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]      DATA_ZERO  = {DATA_WIDTH{1'b0}};

    logic [K_WIDTH-1:0]                log2Decim_r;
    logic                              average_r;
    logic [MAX_LOG2_DECIM-1:0]         phase_r;
    logic signed [ACC_WIDTH-1:0]       acc_r [CHANNELS];
    logic [TIMESTAMP_WIDTH-1:0]        tsFirst_r;
    logic [TRIGGER_WIDTH-1:0]          trigColl_r;

    logic [K_WIDTH-1:0]                kClamped_s;
    logic [K_WIDTH-1:0]                shiftAmt_s;
    logic [MAX_LOG2_DECIM-1:0]         termPhase_s;
    logic                              accept_s;
    logic                              isTerm_s;
    logic                              phaseZero_s;
    logic signed [ACC_WIDTH-1:0]       roundAdd_s;
    logic signed [ACC_WIDTH-1:0]       sampleExt_s [CHANNELS];
    logic signed [ACC_WIDTH-1:0]       sum_s [CHANNELS];
    logic signed [ACC_WIDTH-1:0]       scaled_s [CHANNELS];
    logic [DATA_WIDTH-1:0]             newData_s;
    logic [TIMESTAMP_WIDTH-1:0]        windowTs_s;

    // Config clamp and window terminal-phase decode
    always_comb begin
        kClamped_s = K_MAX;
        if (32'(cfgLog2Decim) > 32'(MAX_LOG2_DECIM)) begin
            kClamped_s = K_MAX;
        end else begin
            kClamped_s = K_WIDTH'(cfgLog2Decim);
        end
        shiftAmt_s  = K_MAX - log2Decim_r;
        termPhase_s = PHASE_ALL >> shiftAmt_s;
        phaseZero_s = (phase_r == PHASE_ZERO);
        accept_s    = inValid & ~cfgUpdate;
        isTerm_s    = accept_s & (phase_r == termPhase_s);
        windowTs_s  = phaseZero_s ? inTimestamp : tsFirst_r;
`ifdef WFR_DECIM_ROUND_EN
        // Half of 2^k, which is zero when k = 0
        roundAdd_s  = $signed((ACC_WIDTH'(termPhase_s) + ACC_ONE) >> 1);
`else
        roundAdd_s  = $signed(ACC_ZERO);
`endif
    end

    // Per-channel running sum including the current sample, and the decimated value
    always_comb begin
        newData_s = DATA_ZERO;
        for (int n = 0; n < CHANNELS; n++) begin
            sampleExt_s[n] = $signed({{MAX_LOG2_DECIM{inData[n*SAMPLE_WIDTH + SAMPLE_WIDTH - 1]}},
                                      inData[n*SAMPLE_WIDTH +: SAMPLE_WIDTH]});
            sum_s[n]       = phaseZero_s ? sampleExt_s[n] : (acc_r[n] + sampleExt_s[n]);
            scaled_s[n]    = (sum_s[n] + roundAdd_s) >>> log2Decim_r;
            if (average_r) begin
                newData_s[n*SAMPLE_WIDTH +: SAMPLE_WIDTH] = scaled_s[n][SAMPLE_WIDTH-1:0];
            end else begin
                newData_s[n*SAMPLE_WIDTH +: SAMPLE_WIDTH] = inData[n*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
        end
    end

    // Latched config, phase counter, first-sample timestamp and trigger collector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            log2Decim_r <= {K_WIDTH{1'b0}};
            average_r   <= 1'b0;
            phase_r     <= PHASE_ZERO;
            tsFirst_r   <= TS_ZERO;
            trigColl_r  <= TRIG_ZERO;
        end else if (cfgUpdate) begin
            log2Decim_r <= kClamped_s;
            average_r   <= cfgAverage;
            phase_r     <= PHASE_ZERO;
            tsFirst_r   <= TS_ZERO;
            trigColl_r  <= TRIG_ZERO;
        end else begin
            if (accept_s) begin
                phase_r <= isTerm_s ? PHASE_ZERO : (phase_r + PHASE_ONE);
                if (phaseZero_s) begin
                    tsFirst_r <= inTimestamp;
                end
            end
            trigColl_r <= isTerm_s ? TRIG_ZERO : (trigColl_r | inTriggers);
        end
    end

    // Channel accumulators
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < CHANNELS; n++) begin
                acc_r[n] <= $signed(ACC_ZERO);
            end
        end else if (cfgUpdate) begin
            for (int n = 0; n < CHANNELS; n++) begin
                acc_r[n] <= $signed(ACC_ZERO);
            end
        end else if (accept_s) begin
            for (int n = 0; n < CHANNELS; n++) begin
                acc_r[n] <= sum_s[n];
            end
        end
    end

    // Registered decimated output; data, triggers and timestamp hold between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid     <= 1'b0;
            outData      <= DATA_ZERO;
            outTriggers  <= TRIG_ZERO;
            outTimestamp <= TS_ZERO;
        end else begin
            outValid <= isTerm_s;
            if (isTerm_s) begin
                outData      <= newData_s;
                outTriggers  <= trigColl_r | inTriggers;
                outTimestamp <= windowTs_s;
            end
        end
    end

    assign windowPhase = phase_r;

endmodule

// File: tb/tb_wfr_sample_decimator.sv
// Self-checking bench for wfr_sample_decimator: directed test-plan cases plus randomized traffic against a window-queue model.
module tb_wfr_sample_decimator;

    localparam int CH   = 4;
    localparam int SW   = 32;
    localparam int MAXK = 8;
    localparam int TSW  = 64;
    localparam int TW   = 8;
    localparam int DW   = CH * SW;

    logic            clk;
    logic            rst;
    logic [3:0]      cfgLog2Decim;
    logic            cfgAverage;
    logic            cfgUpdate;
    logic [DW-1:0]   inData;
    logic            inValid;
    logic [TW-1:0]   inTriggers;
    logic [TSW-1:0]  inTimestamp;
    logic [DW-1:0]   outData;
    logic            outValid;
    logic [TW-1:0]   outTriggers;
    logic [TSW-1:0]  outTimestamp;
    logic [MAXK-1:0] windowPhase;

    wfr_sample_decimator #(
        .CHANNELS(CH), .SAMPLE_WIDTH(SW), .MAX_LOG2_DECIM(MAXK),
        .TIMESTAMP_WIDTH(TSW), .TRIGGER_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfgLog2Decim(cfgLog2Decim), .cfgAverage(cfgAverage), .cfgUpdate(cfgUpdate),
        .inData(inData), .inValid(inValid), .inTriggers(inTriggers), .inTimestamp(inTimestamp),
        .outData(outData), .outValid(outValid), .outTriggers(outTriggers),
        .outTimestamp(outTimestamp), .windowPhase(windowPhase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;
    bit chkEn   = 1'b0;

    // Model state: the current window is a queue of accepted samples
    int             mk;
    bit             mavg;
    logic [DW-1:0]  win [$];
    logic [TSW-1:0] mTs;
    logic [TW-1:0]  mColl;
    // Model outputs after the coming edge, and those currently expected
    logic           nValid, eValid;
    logic [DW-1:0]  nData, eData;
    logic [TW-1:0]  nTrig, eTrig;
    logic [TSW-1:0] nTs, eTs;
    int             nPhase;
    logic [MAXK-1:0] ePhase;

    function automatic longint chan(input logic [DW-1:0] d, input int n);
        logic signed [SW-1:0] v;
        v = d[n*SW +: SW];
        return longint'(v);
    endfunction

    function automatic longint floorDiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic chkVec(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic lit(input string nm, input longint act, input longint exp);
        nChecks++;
        if (act != exp) begin
            nErrors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic modelReset();
        mk = 0; mavg = 1'b0; win.delete(); mTs = '0; mColl = '0;
        nValid = 1'b0; nData = '0; nTrig = '0; nTs = '0; nPhase = 0;
        eValid = 1'b0; eData = '0; eTrig = '0; eTs = '0; ePhase = '0;
    endtask

    task automatic modelStep();
        longint s, num, d;
        if (rst) begin
            modelReset();
        end else begin
            nValid = 1'b0;
            if (cfgUpdate) begin
                mk   = (int'(cfgLog2Decim) > MAXK) ? MAXK : int'(cfgLog2Decim);
                mavg = cfgAverage;
                win.delete();
                mColl = '0;
            end else begin
                if (inValid) begin
                    if (win.size() == 0) mTs = inTimestamp;
                    win.push_back(inData);
                end
                if (inValid && win.size() == (1 << mk)) begin
                    nValid = 1'b1;
                    nTrig  = mColl | inTriggers;
                    mColl  = '0;
                    nTs    = mTs;
                    if (mavg) begin
                        d = longint'(1) << mk;
                        for (int n = 0; n < CH; n++) begin
                            s = 0;
                            foreach (win[i]) s += chan(win[i], n);
                            num = s;
`ifdef WFR_DECIM_ROUND_EN
                            if (mk > 0) num = num + d / 2;
`endif
                            num = floorDiv(num, d);
                            nData[n*SW +: SW] = num[SW-1:0];
                        end
                    end else begin
                        nData = inData;
                    end
                    win.delete();
                end else begin
                    mColl = mColl | inTriggers;
                end
            end
            nPhase = win.size();
        end
    endtask

    task automatic setIdle();
        inValid = 1'b0; cfgUpdate = 1'b0; inTriggers = '0;
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        eValid = nValid; eData = nData; eTrig = nTrig; eTs = nTs; ePhase = MAXK'(nPhase);
        #1;
        setIdle();
    endtask

    task automatic cfg(input logic [3:0] k, input logic avg);
        cfgLog2Decim = k; cfgAverage = avg; cfgUpdate = 1'b1;
        tick();
    endtask

    task automatic smp(input logic [SW-1:0] c0, input logic [SW-1:0] c1,
                       input logic [SW-1:0] c2, input logic [TSW-1:0] ts);
        inValid = 1'b1; inData = {32'h0000_0000, c2, c1, c0}; inTimestamp = ts;
        tick();
    endtask

    // Single compare process against the model on every cycle
    always @(negedge clk) begin
        if (chkEn) begin
            chkVec("outValid", DW'(outValid), DW'(eValid));
            chkVec("outData", outData, eData);
            chkVec("outTriggers", DW'(outTriggers), DW'(eTrig));
            chkVec("outTimestamp", DW'(outTimestamp), DW'(eTs));
            chkVec("windowPhase", DW'(windowPhase), DW'(ePhase));
        end
    end

    initial begin
        rst = 1'b0; cfgLog2Decim = 4'd0; cfgAverage = 1'b0; inData = '0; inTimestamp = '0;
        setIdle();
        modelReset();
        #2 rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chkEn = 1'b1;
        tick();
        lit("reset_valid", longint'(outValid), 64'sd0);
        lit("reset_data", chan(outData, 0), 64'sd0);
        lit("reset_phase", longint'(windowPhase), 64'sd0);

        // k=0 average: every sample passes straight through
        cfg(4'd0, 1'b1);
        smp(32'sd5, 32'sd0, 32'sd0, 64'd11);
        lit("k0_ch0_a", chan(outData, 0), 64'sd5);
        lit("k0_ts_a", longint'(outTimestamp), 64'sd11);
        lit("k0_model_a", chan(eData, 0), 64'sd5);
        smp(-32'sd7, 32'sd0, 32'sd0, 64'd12);
        lit("k0_ch0_b", chan(outData, 0), -64'sd7);
        smp(32'sd9, 32'sd0, 32'sd0, 64'd13);
        lit("k0_ch0_c", chan(outData, 0), 64'sd9);
        lit("k0_ts_c", longint'(outTimestamp), 64'sd13);

        // k=2 average
        cfg(4'd2, 1'b1);
        smp(32'sd4, 32'sd0, 32'sd0, 64'd100);
        smp(32'sd8, 32'sd0, 32'sd0, 64'd101);
        smp(32'sd12, 32'sd0, 32'sd0, 64'd102);
        lit("k2_no_valid", longint'(outValid), 64'sd0);
        smp(32'sd16, 32'sd0, 32'sd0, 64'd103);
        lit("k2_valid", longint'(outValid), 64'sd1);
        lit("k2_ch0", chan(outData, 0), 64'sd10);
        lit("k2_ts", longint'(outTimestamp), 64'sd100);
        lit("k2_model", chan(eData, 0), 64'sd10);

        // k=1 average: negative halves and full-scale positive
        cfg(4'd1, 1'b1);
        smp(32'sd0, -32'sd1, 32'h7FFF_FFFF, 64'd200);
        smp(32'sd0, -32'sd2, 32'h7FFF_FFFF, 64'd201);
`ifdef WFR_DECIM_ROUND_EN
        lit("k1_ch1", chan(outData, 1), -64'sd1);
        lit("k1_model", chan(eData, 1), -64'sd1);
`else
        lit("k1_ch1", chan(outData, 1), -64'sd2);
        lit("k1_model", chan(eData, 1), -64'sd2);
`endif
        lit("k1_ch2", chan(outData, 2), 64'sd2147483647);

        // k=3 pick with a trigger on a non-valid mid-window cycle
        cfg(4'd3, 1'b0);
        for (int i = 1; i <= 4; i++) smp(SW'(i), 32'sd0, 32'sd0, TSW'(300 + i));
        inTriggers = 8'h04;
        tick();
        for (int i = 5; i <= 8; i++) smp(SW'(i), 32'sd0, 32'sd0, TSW'(300 + i));
        lit("k3_ch0", chan(outData, 0), 64'sd8);
        lit("k3_trig", longint'(outTriggers), 64'sd4);
        lit("k3_model_trig", longint'(eTrig), 64'sd4);
        for (int i = 1; i <= 4; i++) smp(SW'(i), 32'sd0, 32'sd0, TSW'(400 + i));
        lit("k3_trig_held", longint'(outTriggers), 64'sd4);
        for (int i = 5; i <= 8; i++) smp(SW'(i), 32'sd0, 32'sd0, TSW'(400 + i));
        lit("k3_trig_clear", longint'(outTriggers), 64'sd0);
        lit("k3_valid2", longint'(outValid), 64'sd1);

        // Partial window dropped by a cfgUpdate carrying its own sample
        cfg(4'd2, 1'b1);
        smp(32'sd7, 32'sd0, 32'sd0, 64'd500);
        smp(32'sd9, 32'sd0, 32'sd0, 64'd501);
        cfgLog2Decim = 4'd1; cfgAverage = 1'b1; cfgUpdate = 1'b1;
        inValid = 1'b1; inData = DW'(100); inTimestamp = 64'd502;
        tick();
        lit("cfg_drop_valid", longint'(outValid), 64'sd0);
        smp(32'sd3, 32'sd0, 32'sd0, 64'd503);
        smp(32'sd5, 32'sd0, 32'sd0, 64'd504);
        lit("cfg_drop_ch0", chan(outData, 0), 64'sd4);
        lit("cfg_drop_ts", longint'(outTimestamp), 64'sd503);

        // Reset mid-window
        cfg(4'd2, 1'b1);
        smp(32'sd1, 32'sd0, 32'sd0, 64'd600);
        smp(32'sd2, 32'sd0, 32'sd0, 64'd601);
        smp(32'sd3, 32'sd0, 32'sd0, 64'd602);
        rst = 1'b1;
        modelReset();
        #1;
        lit("rst_data", chan(outData, 0), 64'sd0);
        lit("rst_ts", longint'(outTimestamp), 64'sd0);
        lit("rst_phase", longint'(windowPhase), 64'sd0);
        tick();
        rst = 1'b0;
        smp(32'sd6, 32'sd0, 32'sd0, 64'd700);
        lit("rst_after_valid", longint'(outValid), 64'sd1);
        lit("rst_after_ch0", chan(outData, 0), 64'sd6);

        // Randomized traffic including clamped k, reconfig and resets
        for (int c = 0; c < 5000; c++) begin
            int r;
            r = int'($urandom_range(0, 199));
            inData      = {$urandom, $urandom, $urandom, $urandom};
            inTimestamp = {$urandom, $urandom};
            inValid     = ($urandom_range(0, 3) != 0);
            inTriggers  = ($urandom_range(0, 7) == 0) ? TW'($urandom) : '0;
            if (r < 3) begin
                cfgLog2Decim = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15))
                                                             : 4'($urandom_range(0, 4));
                cfgAverage   = 1'($urandom);
                cfgUpdate    = 1'b1;
                tick();
            end else if (r == 3) begin
                rst = 1'b1;
                modelReset();
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        tick();

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
